debug_ctrl: RTL and testbench

- UART-side debug controller sitting directly upstream of the CPU top level.
- Consumes bytes from the UART receiver and loads program words into instruction memory.
- Gates the pipeline clock-enable for continuous or single-step execution.
- After execution, streams PC, cycle count and the register file back through the UART transmitter.

---
 rtl/debug_pkg.sv | 29 ++
 rtl/debug_ctrl_if.sv | 34 +++
 rtl/debug_ctrl_tx_word_serializer.sv | 65 ++++++
 rtl/debug_ctrl.sv | 159 +++++++++++++++
 tb/tb_debug_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/debug_pkg.sv
// Shared constants for the UART debug controller: command bytes, dump geometry
// and the controller state encoding.
package debug_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;

  localparam int DUMP_WORDS     = 34;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [3:0] ST_IDLE       = 4'd0;
  localparam logic [3:0] ST_LEN_LO     = 4'd1;
  localparam logic [3:0] ST_LEN_HI     = 4'd2;
  localparam logic [3:0] ST_LOAD_BYTE  = 4'd3;
  localparam logic [3:0] ST_LOAD_WRITE = 4'd4;
  localparam logic [3:0] ST_CPU_RST    = 4'd5;
  localparam logic [3:0] ST_RUN        = 4'd6;
  localparam logic [3:0] ST_STEP       = 4'd7;
  localparam logic [3:0] ST_DUMP_FETCH = 4'd8;
  localparam logic [3:0] ST_DUMP_SEND  = 4'd9;
  localparam logic [3:0] ST_DUMP_WAIT  = 4'd10;

  // Cycle counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/debug_ctrl_if.sv
// Bundle of UART, instruction-memory and CPU-side signals of the debug controller.
// Handshakes: rx_done/tx_start/tx_done are single-cycle pulses; data is valid in the pulse cycle.
interface debug_ctrl_if #(
  parameter int NBITS  = 32,
  parameter int INBITS = 16,
  parameter int REGS   = 5
);
  logic [7:0]        i_rx_data;
  logic              i_rx_done;
  logic [7:0]        o_tx_data;
  logic              o_tx_start;
  logic              i_tx_done;
  logic              o_imem_wr_en;
  logic [INBITS-1:0] o_imem_addr;
  logic [NBITS-1:0]  o_imem_data;
  logic              o_cpu_en;
  logic              o_cpu_reset;
  logic              i_cpu_halt;
  logic [NBITS-1:0]  i_pc;
  logic [REGS-1:0]   o_reg_addr;
  logic [NBITS-1:0]  i_reg_data;

  modport master (
    input  i_rx_data, i_rx_done, i_tx_done, i_cpu_halt, i_pc, i_reg_data,
    output o_tx_data, o_tx_start, o_imem_wr_en, o_imem_addr, o_imem_data,
           o_cpu_en, o_cpu_reset, o_reg_addr
  );

  modport slave (
    output i_rx_data, i_rx_done, i_tx_done, i_cpu_halt, i_pc, i_reg_data,
    input  o_tx_data, o_tx_start, o_imem_wr_en, o_imem_addr, o_imem_data,
           o_cpu_en, o_cpu_reset, o_reg_addr
  );
endinterface

// File: rtl/debug_ctrl_tx_word_serializer.sv
// Sends one 32-bit word as 4 UART bytes, LSB first, using the tx_start/tx_done
// handshake; o_word_done pulses with the tx_done of the last byte.
module tx_word_serializer
  import debug_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_load,
  input  logic [31:0] i_word,
  input  logic        i_tx_done,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_start,
  output logic        o_word_done,
  output logic [1:0]  o_phase
);

  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_SEND = 2'd1;
  localparam logic [1:0] PH_WAIT = 2'd2;

  logic [1:0]  r_phase;
  logic [31:0] r_shift;
  logic [1:0]  r_byte;
  logic        w_last_byte;

  assign w_last_byte = (r_byte == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_phase <= PH_IDLE;
      r_shift <= '0;
      r_byte  <= '0;
    end else begin
      case (r_phase)
        PH_IDLE: begin
          if (i_load) begin
            r_shift <= i_word;
            r_byte  <= '0;
            r_phase <= PH_SEND;
          end
        end
        PH_SEND: r_phase <= PH_WAIT;
        PH_WAIT: begin
          if (i_tx_done) begin
            // The last byte is not shifted out so o_tx_data stays put afterwards.
            if (w_last_byte) begin
              r_phase <= PH_IDLE;
            end else begin
              r_byte  <= r_byte + 2'd1;
              r_shift <= {8'h00, r_shift[31:8]};
              r_phase <= PH_SEND;
            end
          end
        end
        default: r_phase <= PH_IDLE;
      endcase
    end
  end

  assign o_tx_data   = r_shift[7:0];
  assign o_tx_start  = (r_phase == PH_SEND);
  assign o_word_done = (r_phase == PH_WAIT) && i_tx_done && w_last_byte;
  assign o_phase     = r_phase;

endmodule

// File: rtl/debug_ctrl.sv
// UART debug controller: loads program words into instruction memory, runs or
// single-steps the CPU, then dumps PC, cycle count and the register file.
module debug_ctrl
  import debug_pkg::*;
#(
  parameter int NBITS      = 32,
  parameter int INBITS     = 16,
  parameter int CELDAS_REG = 32,
  parameter int REGS       = 5
) (
  input  logic         i_clk,
  input  logic         i_reset,
  debug_ctrl_if.master bus,
  output logic [3:0]   o_dbg_state,
  output logic [1:0]   o_dbg_ser_phase
);

  localparam logic [5:0] LAST_WORD = 6'(CELDAS_REG + 1);

  logic [3:0]        r_state;
  logic [15:0]       r_len;
  logic [15:0]       r_wcnt;
  logic [1:0]        r_bcnt;
  logic [NBITS-1:0]  r_asm;
  logic [INBITS-1:0] r_addr;
  logic [31:0]       r_cycles;
  logic [NBITS-1:0]  r_pc_lat;
  logic [5:0]        r_dump_idx;
  logic [REGS-1:0]   r_reg_idx;

  logic              w_load;
  logic [NBITS-1:0]  w_word;
  logic              w_word_done;
  logic              w_cpu_en;

  assign w_cpu_en = ((r_state == ST_RUN) || (r_state == ST_STEP)) && !bus.i_cpu_halt;
  assign w_load   = (r_state == ST_DUMP_FETCH);

  always_comb begin
    w_word = bus.i_reg_data;
    if (r_dump_idx == 6'd0)      w_word = r_pc_lat;
    else if (r_dump_idx == 6'd1) w_word = r_cycles;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_wcnt     <= '0;
      r_bcnt     <= '0;
      r_asm      <= '0;
      r_addr     <= '0;
      r_cycles   <= '0;
      r_pc_lat   <= '0;
      r_dump_idx <= '0;
      r_reg_idx  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.i_rx_done) begin
            case (bus.i_rx_data)
              CMD_LOAD: r_state <= ST_LEN_LO;
              CMD_RUN:  r_state <= ST_RUN;
              CMD_STEP: r_state <= ST_STEP;
              default:  r_state <= ST_IDLE;
            endcase
          end
        end
        ST_LEN_LO: begin
          if (bus.i_rx_done) begin
            r_len[7:0] <= bus.i_rx_data;
            r_state    <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (bus.i_rx_done) begin
            r_len[15:8] <= bus.i_rx_data;
            r_addr      <= '0;
            r_wcnt      <= '0;
            r_bcnt      <= '0;
            r_state     <= ({bus.i_rx_data, r_len[7:0]} == 16'd0) ? ST_CPU_RST : ST_LOAD_BYTE;
          end
        end
        ST_LOAD_BYTE: begin
          if (bus.i_rx_done) begin
            r_asm[{r_bcnt, 3'b000} +: 8] <= bus.i_rx_data;
            r_bcnt <= r_bcnt + 2'd1;
            if (r_bcnt == 2'd3) r_state <= ST_LOAD_WRITE;
          end
        end
        ST_LOAD_WRITE: begin
          r_addr  <= r_addr + 1'b1;
          r_wcnt  <= r_wcnt + 16'd1;
          r_state <= ((r_wcnt + 16'd1) == r_len) ? ST_CPU_RST : ST_LOAD_BYTE;
        end
        ST_CPU_RST: begin
          r_cycles <= '0;
          r_state  <= ST_IDLE;
        end
        ST_RUN: begin
          if (bus.i_cpu_halt) begin
            r_pc_lat   <= bus.i_pc;
            r_dump_idx <= '0;
            r_reg_idx  <= '0;
            r_state    <= ST_DUMP_FETCH;
          end else begin
            r_cycles <= sat_inc32(r_cycles);
          end
        end
        ST_STEP: begin
          if (!bus.i_cpu_halt) r_cycles <= sat_inc32(r_cycles);
          r_pc_lat   <= bus.i_pc;
          r_dump_idx <= '0;
          r_reg_idx  <= '0;
          r_state    <= ST_DUMP_FETCH;
        end
        ST_DUMP_FETCH: r_state <= ST_DUMP_SEND;
        ST_DUMP_SEND:  r_state <= ST_DUMP_WAIT;
        ST_DUMP_WAIT: begin
          if (bus.i_tx_done) begin
            if (!w_word_done) begin
              r_state <= ST_DUMP_SEND;
            end else if (r_dump_idx == LAST_WORD) begin
              r_reg_idx <= '0;
              r_state   <= ST_IDLE;
            end else begin
              // Words 0 and 1 are PC and cycle count; registers start at word 2.
              if (r_dump_idx >= 6'd2) r_reg_idx <= r_reg_idx + 1'b1;
              r_dump_idx <= r_dump_idx + 6'd1;
              r_state    <= ST_DUMP_FETCH;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  tx_word_serializer u_ser (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_load      (w_load),
    .i_word      (w_word),
    .i_tx_done   (bus.i_tx_done),
    .o_tx_data   (bus.o_tx_data),
    .o_tx_start  (bus.o_tx_start),
    .o_word_done (w_word_done),
    .o_phase     (o_dbg_ser_phase)
  );

  assign bus.o_imem_wr_en = (r_state == ST_LOAD_WRITE);
  assign bus.o_imem_addr  = r_addr;
  assign bus.o_imem_data  = r_asm;
  assign bus.o_cpu_en     = w_cpu_en;
  assign bus.o_cpu_reset  = (r_state == ST_CPU_RST);
  assign bus.o_reg_addr   = r_reg_idx;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_debug_ctrl.sv
// Bench for debug_ctrl: table-driven command/load vectors, run/step dumps
// checked byte-by-byte against an expected queue, and reset corner cases.
module tb_debug_ctrl;
  import debug_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  debug_ctrl_if #(.NBITS(32), .INBITS(16), .REGS(5)) bus();
  logic [3:0] dbg_state;
  logic [1:0] ser_phase;

  debug_ctrl #(.NBITS(32), .INBITS(16), .CELDAS_REG(32), .REGS(5)) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .bus             (bus),
    .o_dbg_state     (dbg_state),
    .o_dbg_ser_phase (ser_phase)
  );

  logic [31:0] regs [32];
  assign bus.i_reg_data = regs[bus.o_reg_addr];

  logic [7:0]  exp_q [$];
  logic [47:0] exp_wr_q [$];
  int n_tests = 0, n_fail = 0;
  int en_cnt = 0, rst_pulses = 0, wr_cnt = 0, tx_cnt = 0;
  logic [7:0]  last_tx = 8'h00;
  logic [31:0] exp_cycles = 32'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_cpu_en) en_cnt++;
      if (bus.o_cpu_reset) rst_pulses++;
      if (bus.o_imem_wr_en) begin
        wr_cnt++;
        if (exp_wr_q.size() == 0) check("unexpected_write", {bus.o_imem_addr, bus.o_imem_data}, 48'h0);
        else check("imem_write", {bus.o_imem_addr, bus.o_imem_data}, exp_wr_q.pop_front());
      end
      if (bus.o_tx_start) begin
        tx_cnt++;
        last_tx = bus.o_tx_data;
        if (exp_q.size() == 0) check("unexpected_tx", {56'h0, bus.o_tx_data}, 64'h1ff);
        else check("tx_byte", {56'h0, bus.o_tx_data}, {56'h0, exp_q.pop_front()});
      end
      if (dbg_state == ST_DUMP_WAIT) check("tx_hold", {56'h0, bus.o_tx_data}, {56'h0, last_tx});
    end
  end

  // UART transmitter model: finish each byte 1..3 cycles after its start pulse.
  initial begin
    bus.i_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.o_tx_start && !rst) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1 bus.i_tx_done = 1'b1;
        @(posedge clk);
        #1 bus.i_tx_done = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk);
    #1 bus.i_rx_data = b; bus.i_rx_done = 1'b1;
    @(posedge clk);
    #1 bus.i_rx_done = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic wait_idle(input int budget, input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dbg_state == ST_IDLE) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, ok, 1);
  endtask

  task automatic push_dump(input logic [31:0] pc, input logic [31:0] cyc);
    logic [31:0] w;
    for (int k = 0; k < DUMP_WORDS; k++) begin
      w = (k == 0) ? pc : (k == 1) ? cyc : regs[k-2];
      for (int b = 0; b < BYTES_PER_WORD; b++) exp_q.push_back(w[8*b +: 8]);
    end
  endtask

  // halt_after > 0: raise halt after that many enabled cycles.
  task automatic run_dump(input logic [7:0] cmd, input logic [31:0] pc, input int halt_after,
                          input logic halt_init, input int exp_en, input string name);
    int base_en, base_tx;
    logic hit;
    bus.i_pc = pc;
    bus.i_cpu_halt = halt_init;
    exp_cycles = exp_cycles + 32'(exp_en);
    push_dump(pc, exp_cycles);
    base_en = en_cnt;
    base_tx = tx_cnt;
    send_byte(cmd, 0);
    if (halt_after > 0) begin
      hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(posedge clk);
        if (en_cnt - base_en == halt_after) begin
          hit = 1'b1;
          break;
        end
      end
      #1 bus.i_cpu_halt = 1'b1;
      check({name, "_halt_reached"}, hit, 1);
    end
    // A command byte arriving mid-dump must be dropped.
    repeat (10) @(posedge clk);
    send_byte(CMD_LOAD, 0);
    wait_idle(3000, {name, "_dump_done"});
    check({name, "_en_cycles"}, en_cnt - base_en, exp_en);
    check({name, "_tx_pulses"}, tx_cnt - base_tx, DUMP_WORDS * BYTES_PER_WORD);
    check({name, "_exp_q_empty"}, exp_q.size(), 0);
    bus.i_cpu_halt = 1'b0;
  endtask

  typedef struct {
    logic [7:0] b;
    logic [3:0] exp_state;
  } idle_vec_t;

  typedef struct {
    int          n;
    logic [31:0] w [3];
  } load_vec_t;

  idle_vec_t iv [5];
  load_vec_t lv [3];

  initial begin
    int base_wr, base_rst, base_en;
    logic [31:0] word;

    iv[0] = '{8'h99, ST_IDLE};
    iv[1] = '{8'h58, ST_IDLE};
    iv[2] = '{8'h00, ST_IDLE};
    iv[3] = '{8'hFF, ST_IDLE};
    iv[4] = '{8'h6C, ST_IDLE};
    lv[0].n = 2; lv[0].w[0] = 32'h0100_0820; lv[0].w[1] = 32'hFC00_0000; lv[0].w[2] = 32'h0;
    lv[1].n = 0; lv[1].w[0] = 32'h0;         lv[1].w[1] = 32'h0;         lv[1].w[2] = 32'h0;
    lv[2].n = 3; lv[2].w[0] = $urandom;      lv[2].w[1] = $urandom;      lv[2].w[2] = $urandom;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[5] = 32'hDEAD_BEEF;

    rst = 1'b1;
    bus.i_rx_data = 8'h00; bus.i_rx_done = 1'b0; bus.i_cpu_halt = 1'b0; bus.i_pc = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_ser_phase", ser_phase, 0);
    check("rst_outputs", {bus.o_cpu_en, bus.o_cpu_reset, bus.o_imem_wr_en, bus.o_tx_start}, 0);
    check("rst_imem_addr", bus.o_imem_addr, 0);
    check("rst_imem_data", bus.o_imem_data, 0);
    check("rst_tx_data", bus.o_tx_data, 0);
    check("rst_reg_addr", bus.o_reg_addr, 0);

    // Unknown command bytes are ignored in IDLE.
    base_rst = rst_pulses; base_en = en_cnt; base_wr = wr_cnt;
    for (int i = 0; i < 5; i++) begin
      send_byte(iv[i].b, 1);
      @(negedge clk);
      check("idle_byte_state", dbg_state, iv[i].exp_state);
    end
    check("idle_no_side_effects", {32'(rst_pulses - base_rst), 32'(en_cnt - base_en + wr_cnt - base_wr)}, 0);

    for (int t = 0; t < 3; t++) begin
      base_wr = wr_cnt; base_rst = rst_pulses;
      for (int i = 0; i < lv[t].n; i++) exp_wr_q.push_back({16'(i), lv[t].w[i]});
      send_byte(CMD_LOAD, $urandom_range(0, 2));
      send_byte(8'(lv[t].n), $urandom_range(0, 2));
      send_byte(8'(lv[t].n >> 8), $urandom_range(0, 2));
      for (int i = 0; i < lv[t].n; i++) begin
        word = lv[t].w[i];
        for (int b = 0; b < 4; b++) send_byte(word[8*b +: 8], $urandom_range(0, 2));
      end
      wait_idle(50, "load_idle");
      check("load_writes", wr_cnt - base_wr, lv[t].n);
      check("load_cpu_reset", rst_pulses - base_rst, 1);
      check("load_wr_q_empty", exp_wr_q.size(), 0);
      exp_cycles = 32'd0;
    end

    // Reset in the middle of a word: nothing written, back to IDLE.
    base_wr = wr_cnt;
    send_byte(CMD_LOAD, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midload_rst_state", dbg_state, ST_IDLE);
    check("midload_rst_no_write", wr_cnt - base_wr, 0);
    check("midload_rst_imem_data", bus.o_imem_data, 0);

    base_wr = wr_cnt; base_rst = rst_pulses;
    exp_wr_q.push_back({16'h0000, 32'h1234_5678});
    send_byte(CMD_LOAD, 1); send_byte(8'h01, 1); send_byte(8'h00, 1);
    send_byte(8'h78, 0); send_byte(8'h56, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
    wait_idle(50, "reload_idle");
    check("reload_writes", wr_cnt - base_wr, 1);
    check("reload_cpu_reset", rst_pulses - base_rst, 1);
    exp_cycles = 32'd0;

    run_dump(CMD_RUN,  32'h0000_0100, 7, 1'b0, 7, "run");
    run_dump(CMD_STEP, 32'h0000_0004, 0, 1'b0, 1, "step");
    run_dump(CMD_STEP, 32'h0000_0008, 0, 1'b1, 0, "halted_step");
    run_dump(CMD_RUN,  32'h0000_000C, 0, 1'b1, 0, "halted_run");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
